alu_simple: RTL and testbench

ALU_SIMPLE -- requirements
Module: alu_simple

---
 rtl/alu_simple_pkg.sv | 23 ++
 rtl/alu_simple_if.sv | 22 ++
 rtl/alu_shifter.sv | 40 ++++
 rtl/alu_simple.sv | 58 +++++
 tb/tb_alu_simple.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/alu_simple_pkg.sv
// Shared opcode and shift-control encodings for alu_simple.
// Rotate encodings are always defined; ALU_SIMPLE_ROTATE_EN only gates the logic.
package alu_simple_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_XOR = 4'b0101
    } alu_op_e;

    typedef enum logic [2:0] {
        SR_NONE = 3'b000,
        SR_SRL  = 3'b001,
        SR_SLL  = 3'b010,
        SR_ROR  = 3'b011,
        SR_ROL  = 3'b100,
        SR_SRA  = 3'b101
    } sr_cont_e;

endpackage

// File: rtl/alu_simple_if.sv
// Operand/control/result bundle for alu_simple; master drives operands, slave returns Out.
interface alu_simple_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic [DATA_W-1:0]  In1;
    logic [DATA_W-1:0]  In2;
    logic [3:0]         opcode;
    logic [2:0]         SR_Cont;
    logic [SHAMT_W-1:0] SR_Bit;
    logic [DATA_W-1:0]  Out;

    modport master (
        output In1, In2, opcode, SR_Cont, SR_Bit,
        input  Out
    );

    modport slave (
        input  In1, In2, opcode, SR_Cont, SR_Bit,
        output Out
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit operating on In2.
// Rotates are compiled only when ALU_SIMPLE_ROTATE_EN is defined; otherwise they yield 0.
module alu_shifter
    import alu_simple_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [DATA_W-1:0]  In2,
    input  logic [2:0]         SR_Cont,
    input  logic [SHAMT_W-1:0] SR_Bit,
    output logic [DATA_W-1:0]  sh_out
);

`ifdef ALU_SIMPLE_ROTATE_EN
    // Shifting a doubled copy avoids the shift-by-DATA_W corner case at SR_Bit = 0.
    logic [2*DATA_W-1:0] dbl_r;
    logic [2*DATA_W-1:0] dbl_l;

    always_comb begin
        dbl_r = {In2, In2} >> SR_Bit;
        dbl_l = {In2, In2} << SR_Bit;
    end
`endif

    always_comb begin
        sh_out = '0;
        case (SR_Cont)
            SR_SRL: sh_out = In2 >> SR_Bit;
            SR_SLL: sh_out = In2 << SR_Bit;
            SR_SRA: sh_out = DATA_W'($signed(In2) >>> SR_Bit);
`ifdef ALU_SIMPLE_ROTATE_EN
            SR_ROR: sh_out = dbl_r[DATA_W-1:0];
            SR_ROL: sh_out = dbl_l[2*DATA_W-1:DATA_W];
`endif
            default: sh_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_simple.sv
// Registered ALU: arithmetic/logic by opcode, or shift/rotate of In2 when SR_Cont != 0.
// Rotate modes depend on ALU_SIMPLE_ROTATE_EN (see alu_shifter).
module alu_simple
    import alu_simple_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  In1,
    input  logic [DATA_W-1:0]  In2,
    input  logic [3:0]         opcode,
    input  logic [2:0]         SR_Cont,
    input  logic [SHAMT_W-1:0] SR_Bit,
    output logic [DATA_W-1:0]  Out
);

    logic [DATA_W-1:0] sh_out;
    logic [DATA_W-1:0] res;

    alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .In2     (In2),
        .SR_Cont (SR_Cont),
        .SR_Bit  (SR_Bit),
        .sh_out  (sh_out)
    );

    // Any nonzero SR_Cont selects the shifter, so opcode is a don't-care there.
    always_comb begin
        res = '0;
        if (SR_Cont != SR_NONE) begin
            res = sh_out;
        end else begin
            case (opcode)
                OP_ADD:  res = In1 + In2;
                OP_SUB:  res = In1 - In2;
                OP_MUL:  res = In1 * In2;
                OP_OR:   res = In1 | In2;
                OP_AND:  res = In1 & In2;
                OP_XOR:  res = In1 ^ In2;
                default: res = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Out <= '0;
        end else begin
            Out <= res;
        end
    end

endmodule

// File: tb/tb_alu_simple.sv
// Directed-vector bench for alu_simple; expected values are hand-computed constants.
// Rotate expectations follow ALU_SIMPLE_ROTATE_EN.
module tb_alu_simple;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    alu_simple_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

    alu_simple #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .In1     (bus.In1),
        .In2     (bus.In2),
        .opcode  (bus.opcode),
        .SR_Cont (bus.SR_Cont),
        .SR_Bit  (bus.SR_Bit),
        .Out     (bus.Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] sr,
                         input logic [SHAMT_W-1:0] sb,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.opcode  = op;
        bus.SR_Cont = sr;
        bus.SR_Bit  = sb;
        bus.In1     = a;
        bus.In2     = b;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [2:0] sr,
                           input logic [SHAMT_W-1:0] sb, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp);
        drive(op, sr, sb, a, b);
        step();
        check_out(tag, bus.Out, exp);
    endtask

    logic [DATA_W-1:0] exp_ror;
    logic [DATA_W-1:0] exp_rol;
    logic [DATA_W-1:0] exp_ror0;

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef ALU_SIMPLE_ROTATE_EN
        exp_ror  = 32'hC000_0000;
        exp_rol  = 32'h0000_0003;
        exp_ror0 = 32'h8000_0001;
`else
        exp_ror  = 32'h0;
        exp_rol  = 32'h0;
        exp_ror0 = 32'h0;
`endif

        // Reset held for two edges with an add pending, then released.
        rst_n = 1'b0;
        drive(4'b0000, 3'b000, 5'd0, 32'd15, 32'd20);
        step();
        check_out("rst_edge1", bus.Out, 32'd0);
        step();
        check_out("rst_edge2", bus.Out, 32'd0);
        rst_n = 1'b1;
        step();
        check_out("rst_release_add", bus.Out, 32'd35);

        // Arithmetic
        run_vec("add_wrap",  4'b0000, 3'b000, 5'd0, 32'hFFFF_FFFF, 32'd2,      32'd1);
        run_vec("sub",       4'b0001, 3'b000, 5'd0, 32'd30,        32'd10,     32'd20);
        run_vec("sub_wrap",  4'b0001, 3'b000, 5'd0, 32'd0,         32'd1,      32'hFFFF_FFFF);
        run_vec("mul",       4'b0010, 3'b000, 5'd0, 32'd5,         32'd5,      32'd25);
        run_vec("mul_ovf",   4'b0010, 3'b000, 5'd0, 32'h0001_0000, 32'h0001_0000, 32'd0);

        // Logic and undefined opcodes
        run_vec("or",        4'b0011, 3'b000, 5'd0, 32'h0A0, 32'h005, 32'h0A5);
        run_vec("and",       4'b0100, 3'b000, 5'd0, 32'h0F0, 32'h00F, 32'h000);
        run_vec("xor",       4'b0101, 3'b000, 5'd0, 32'h0FF, 32'h0F0, 32'h00F);
        run_vec("op0111",    4'b0111, 3'b000, 5'd0, 32'h0FF, 32'h0F0, 32'h000);
        run_vec("op1111",    4'b1111, 3'b000, 5'd0, 32'hFFFF, 32'h1234, 32'h000);

        // Shifts; opcode unknown and In1 nonzero must not matter
        run_vec("srl4",      4'bxxxx, 3'b001, 5'd4, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0123_4567);
        run_vec("sll4",      4'bxxxx, 3'b010, 5'd4, 32'hDEAD_BEEF, 32'h1234_5678, 32'h2345_6780);
        run_vec("srl0",      4'bxxxx, 3'b001, 5'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678);
        run_vec("sll0",      4'b0011, 3'b010, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678);
        run_vec("srl31",     4'b0000, 3'b001, 5'd31, 32'd0,        32'h8000_0000, 32'h0000_0001);

        // Rotate / arithmetic shift / reserved codes
        run_vec("ror1",      4'bxxxx, 3'b011, 5'd1, 32'd7, 32'h8000_0001, exp_ror);
        run_vec("rol1",      4'bxxxx, 3'b100, 5'd1, 32'd7, 32'h8000_0001, exp_rol);
        run_vec("ror0",      4'bxxxx, 3'b011, 5'd0, 32'd7, 32'h8000_0001, exp_ror0);
        run_vec("sra1",      4'bxxxx, 3'b101, 5'd1, 32'd7, 32'h8000_0001, 32'hC000_0000);
        run_vec("sra4_pos",  4'bxxxx, 3'b101, 5'd4, 32'd7, 32'h7000_0000, 32'h0700_0000);
        run_vec("sr110",     4'bxxxx, 3'b110, 5'd1, 32'd7, 32'h8000_0001, 32'd0);
        run_vec("sr111",     4'b0011, 3'b111, 5'd1, 32'd7, 32'h8000_0001, 32'd0);

        // Back-to-back: each check consumes exactly one edge, next op driven immediately
        run_vec("b2b_add",   4'b0000, 3'b000, 5'd0, 32'd100, 32'd23,  32'd123);
        run_vec("b2b_sll",   4'b0000, 3'b010, 5'd8, 32'd100, 32'h0000_00AB, 32'h0000_AB00);
        run_vec("b2b_mul",   4'b0010, 3'b000, 5'd0, 32'd7,   32'd6,   32'd42);
        run_vec("b2b_xor",   4'b0101, 3'b000, 5'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        run_vec("b2b_sra",   4'b0000, 3'b101, 5'd31, 32'd0,  32'h8000_0000, 32'hFFFF_FFFF);
        run_vec("b2b_sub",   4'b0001, 3'b000, 5'd0, 32'd5,   32'd7,   32'hFFFF_FFFE);

        // Mid-stream reset overrides a pending op, then the first released edge computes
        drive(4'b0011, 3'b000, 5'd0, 32'hF000_0000, 32'h0000_000F);
        rst_n = 1'b0;
        step();
        check_out("midrst", bus.Out, 32'd0);
        rst_n = 1'b1;
        step();
        check_out("midrst_release", bus.Out, 32'hF000_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1);
    end

endmodule
